// File: rtl/seq_detector_moore_p.sv
// seq_detector_moore_p
// Moore serial pattern detector for a LEN-bit pattern that can be reloaded at
// runtime. The state is the length of the longest pattern prefix that is also
// a suffix of the bits accepted since the last restart. A saturating counter
// counts completed matches. Every output comes from a register, so there is no
// combinational path from IN to any output.

module seq_detector_moore_p #(
  parameter int             LEN     = 3,
  parameter logic [LEN-1:0] PATTERN = 3'b101,
  parameter bit             OVERLAP = 1'b1,
  parameter int             CNT_W   = 8,
  parameter int             SW      = $clog2(LEN + 1)
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             IN,
  input  logic             In_valid,
  input  logic [LEN-1:0]   Pat_in,
  input  logic             Pat_load,
  input  logic             Cnt_clr,
  output logic             Out_1,
  output logic [SW-1:0]    Estado_Salida,
  output logic [CNT_W-1:0] Match_count
);

  // Named states: empty match and full match. The states in between are the
  // number of pattern bits matched so far.
  localparam logic [SW-1:0]    ST_IDLE = '0;
  localparam logic [SW-1:0]    ST_FULL = SW'(LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // The history holds the last LEN-1 accepted bits. Together with the
  // incoming bit, this gives a window of LEN bits. For LEN=1 no history is
  // needed, but the register keeps a legal width of one bit.
  localparam int HW = (LEN > 1) ? LEN - 1 : 1;

  logic [SW-1:0]    state_q, state_d;
  logic [LEN-1:0]   pat_q, pat_d;
  logic [HW-1:0]    hist_q, hist_d;
  logic [SW-1:0]    hlen_q, hlen_d;   // bits accepted since restart, capped at LEN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             accept;
  logic             restart_full;
  logic [SW-1:0]    base_len;
  logic [SW-1:0]    avail;
  logic [LEN-1:0]   window;
  logic [LEN-1:0]   match_vec;        // bit j-1: last j bits equal first j pattern bits
  logic [SW-1:0]    cand_state;
  logic             cnt_inc;

  // A pattern load wins over a valid bit, and that bit is dropped.
  assign accept = In_valid & ~Pat_load;

  // In non-overlapping mode, a bit accepted in the full-match state starts a
  // fresh search. Earlier bits are then ignored.
  assign restart_full = (OVERLAP == 1'b0) && (state_q == ST_FULL);
  assign base_len     = restart_full ? ST_IDLE : hlen_q;
  assign avail        = (base_len == ST_FULL) ? ST_FULL : base_len + SW'(1);

  // Build the candidate window: the stored history with the new bit in the LSB.
  generate
    if (LEN == 1) begin : g_win1
      assign window = IN;
    end else begin : g_winn
      assign window = {hist_q[LEN-2:0], IN};
    end
  endgenerate

  // Test each prefix length j. A length is a candidate only if that many bits
  // have been accepted since the last restart.
  genvar gi;
  generate
    for (gi = 1; gi <= LEN; gi++) begin : g_match
      assign match_vec[gi-1] = (SW'(gi) <= avail) &&
                               (window[gi-1:0] == pat_q[LEN-1:LEN-gi]);
    end
  endgenerate

  // Pick the longest matching prefix as the next state.
  always_comb begin
    cand_state = ST_IDLE;
    for (int j = 1; j <= LEN; j++) begin
      if (match_vec[j-1]) begin
        cand_state = SW'(j);
      end
    end
  end

  // Next-state logic for the state, pattern and history registers.
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    hist_d  = hist_q;
    hlen_d  = hlen_q;
    if (Pat_load) begin
      pat_d   = Pat_in;
      state_d = ST_IDLE;
      hist_d  = '0;
      hlen_d  = '0;
    end else if (In_valid) begin
      state_d = cand_state;
      hist_d  = window[HW-1:0];
      hlen_d  = avail;
    end
  end

  // The counter counts every accepted bit that lands in the full state. A
  // clear on the same cycle wins over the increment.
  assign cnt_inc = accept && (cand_state == ST_FULL);

  // Next value of the match counter: clear, saturating increment, or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (Cnt_clr) begin
      cnt_d = '0;
    end else if (cnt_inc && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Detector registers. Reset returns to the default pattern with empty history.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      pat_q   <= PATTERN;
      hist_q  <= '0;
      hlen_q  <= '0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      hist_q  <= hist_d;
      hlen_q  <= hlen_d;
    end
  end

  // Match counter register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign Out_1         = (state_q == ST_FULL);
  assign Estado_Salida = state_q;
  assign Match_count   = cnt_q;

endmodule

// File: tb/tb_seq_detector_moore_p.sv
// Testbench for seq_detector_moore_p.
// There are three instances:
//   dut_a - default parameters (overlapping matches)
//   dut_b - OVERLAP=0
//   dut_c - LEN=1, PATTERN=1, CNT_W=2
// The bench runs directed table vectors, hand-written corner cases, and then
// a random phase checked against a history-queue reference model.

module tb_seq_detector_moore_p;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_b, vld, load, clr;
  logic [2:0] pat_in;

  logic       out_a, out_b;
  logic [1:0] st_a, st_b;
  logic [7:0] cnt_a, cnt_b;

  logic       in_c, vld_c, load_c, clr_c;
  logic [0:0] pat_c;
  logic       out_c;
  logic [0:0] st_c;
  logic [1:0] cnt_c;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_detector_moore_p dut_a (
    .Clk(clk), .Reset_n(rst_n), .IN(in_b), .In_valid(vld), .Pat_in(pat_in),
    .Pat_load(load), .Cnt_clr(clr), .Out_1(out_a), .Estado_Salida(st_a),
    .Match_count(cnt_a)
  );

  seq_detector_moore_p #(.OVERLAP(1'b0)) dut_b (
    .Clk(clk), .Reset_n(rst_n), .IN(in_b), .In_valid(vld), .Pat_in(pat_in),
    .Pat_load(load), .Cnt_clr(clr), .Out_1(out_b), .Estado_Salida(st_b),
    .Match_count(cnt_b)
  );

  seq_detector_moore_p #(.LEN(1), .PATTERN(1'b1), .CNT_W(2)) dut_c (
    .Clk(clk), .Reset_n(rst_n), .IN(in_c), .In_valid(vld_c), .Pat_in(pat_c),
    .Pat_load(load_c), .Cnt_clr(clr_c), .Out_1(out_c), .Estado_Salida(st_c),
    .Match_count(cnt_c)
  );

  typedef struct {
    logic       v;
    logic       b;
    logic       l;
    logic [2:0] p;
    logic       c;
    int         sa;
    int         ca;
    int         sb;
    int         cb;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic v, input logic b, input logic l, input logic [2:0] p,
                     input logic c, input int sa, input int ca, input int sb, input int cb);
    vec_t r;
    r.v = v; r.b = b; r.l = l; r.p = p; r.c = c;
    r.sa = sa; r.ca = ca; r.sb = sb; r.cb = cb;
    tbl.push_back(r);
  endtask

  task automatic chk(input string nm, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ab(input logic v, input logic b);
    vld = v; in_b = b; load = 1'b0; clr = 1'b0;
  endtask

  task automatic drive_c(input logic v, input logic b, input logic c);
    vld_c = v; in_c = b; clr_c = c;
  endtask

  // Length of the longest pattern prefix that is a suffix of the bits
  // accepted since the last restart.
  function automatic int longest(input bit q[$], input logic [2:0] p);
    int n;
    int top;
    bit ok;
    n = q.size();
    top = (n < 3) ? n : 3;
    for (int j = top; j >= 1; j--) begin
      ok = 1'b1;
      for (int i = 0; i < j; i++) begin
        if (q[n - j + i] != p[2 - i]) ok = 1'b0;
      end
      if (ok) return j;
    end
    return 0;
  endfunction

  // Asynchronous reset pulse, applied and released away from clock edges.
  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_st_a", int'(st_a), 0);
    chk("async_rst_out_a", int'(out_a), 0);
    chk("async_rst_cnt_a", int'(cnt_a), 0);
    chk("async_rst_st_b", int'(st_b), 0);
    chk("async_rst_cnt_b", int'(cnt_b), 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  initial begin
    bit         qa[$];
    bit         qb[$];
    int         msa, mca, msb, mcb;
    logic [2:0] mpat;
    logic       rv, rb, rl, rc;
    logic [2:0] rp;

    rst_n = 1'b0;
    vld = 0; in_b = 0; load = 0; clr = 0; pat_in = 3'b000;
    vld_c = 0; in_c = 0; load_c = 0; clr_c = 0; pat_c = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_st_a", int'(st_a), 0);
    chk("reset_out_a", int'(out_a), 0);
    chk("reset_cnt_a", int'(cnt_a), 0);
    chk("reset_st_b", int'(st_b), 0);
    chk("reset_st_c", int'(st_c), 0);
    chk("reset_cnt_c", int'(cnt_c), 0);
    rst_n = 1'b1;

    // Directed vectors for dut_a and dut_b, which share the same inputs.
    //  v  b  l  pat     c   st_a cnt_a st_b cnt_b
    add(1, 1, 0, 3'b000, 0,  1, 0,  1, 0);
    add(1, 0, 0, 3'b000, 0,  2, 0,  2, 0);
    add(1, 1, 0, 3'b000, 0,  3, 1,  3, 1);
    add(1, 0, 0, 3'b000, 0,  2, 1,  0, 1);
    add(1, 1, 0, 3'b000, 0,  3, 2,  1, 1);
    add(1, 1, 1, 3'b101, 0,  0, 2,  0, 1);   // load drops the valid bit
    add(1, 1, 0, 3'b000, 0,  1, 2,  1, 1);
    add(0, 0, 0, 3'b000, 0,  1, 2,  1, 1);
    add(0, 1, 0, 3'b000, 0,  1, 2,  1, 1);
    add(0, 1, 0, 3'b000, 0,  1, 2,  1, 1);
    add(0, 0, 0, 3'b000, 0,  1, 2,  1, 1);
    add(1, 0, 0, 3'b000, 0,  2, 2,  2, 1);
    add(0, 1, 0, 3'b000, 0,  2, 2,  2, 1);
    add(0, 1, 0, 3'b000, 0,  2, 2,  2, 1);
    add(0, 1, 0, 3'b000, 0,  2, 2,  2, 1);
    add(0, 1, 0, 3'b000, 0,  2, 2,  2, 1);
    add(1, 1, 0, 3'b000, 0,  3, 3,  3, 2);
    add(0, 0, 0, 3'b000, 0,  3, 3,  3, 2);   // flag held without valid
    add(0, 1, 0, 3'b000, 0,  3, 3,  3, 2);
    add(1, 1, 0, 3'b000, 0,  1, 3,  1, 2);
    add(1, 0, 0, 3'b000, 0,  2, 3,  2, 2);
    add(1, 1, 1, 3'b110, 0,  0, 3,  0, 2);   // new pattern 110
    add(1, 1, 0, 3'b000, 0,  1, 3,  1, 2);
    add(1, 1, 0, 3'b000, 0,  2, 3,  2, 2);
    add(1, 0, 0, 3'b000, 0,  3, 4,  3, 3);
    add(1, 1, 0, 3'b000, 0,  1, 4,  1, 3);
    add(1, 1, 0, 3'b000, 1,  2, 0,  2, 0);   // clear
    add(1, 0, 0, 3'b000, 0,  3, 1,  3, 1);
    add(0, 0, 0, 3'b000, 1,  3, 0,  3, 0);   // clear beats nothing, state holds
    add(0, 0, 1, 3'b111, 0,  0, 0,  0, 0);   // all-ones pattern
    add(1, 1, 0, 3'b000, 0,  1, 0,  1, 0);
    add(1, 1, 0, 3'b000, 0,  2, 0,  2, 0);
    add(1, 1, 0, 3'b000, 0,  3, 1,  3, 1);
    add(1, 1, 0, 3'b000, 0,  3, 2,  1, 1);   // full to full when overlapping
    add(1, 1, 0, 3'b000, 0,  3, 3,  2, 1);
    add(1, 1, 0, 3'b000, 0,  3, 4,  3, 2);

    foreach (tbl[i]) begin
      vld = tbl[i].v; in_b = tbl[i].b; load = tbl[i].l; pat_in = tbl[i].p; clr = tbl[i].c;
      tick();
      $display("row %0d: v=%0b in=%0b load=%0b clr=%0b -> st_a=%0d cnt_a=%0d st_b=%0d cnt_b=%0d",
               i, tbl[i].v, tbl[i].b, tbl[i].l, tbl[i].c, st_a, cnt_a, st_b, cnt_b);
      chk($sformatf("tbl%0d_st_a", i), int'(st_a), tbl[i].sa);
      chk($sformatf("tbl%0d_out_a", i), int'(out_a), (tbl[i].sa == 3) ? 1 : 0);
      chk($sformatf("tbl%0d_cnt_a", i), int'(cnt_a), tbl[i].ca);
      chk($sformatf("tbl%0d_st_b", i), int'(st_b), tbl[i].sb);
      chk($sformatf("tbl%0d_out_b", i), int'(out_b), (tbl[i].sb == 3) ? 1 : 0);
      chk($sformatf("tbl%0d_cnt_b", i), int'(cnt_b), tbl[i].cb);
    end

    // Reset in state 2 under pattern 111, then check the default pattern is back.
    drive_ab(1, 0); tick();
    drive_ab(1, 1); tick();
    drive_ab(1, 1); tick();
    chk("pre_rst_st_a", int'(st_a), 2);
    drive_ab(0, 0);
    pulse_reset();
    drive_ab(1, 1); tick(); chk("post_rst_st1", int'(st_a), 1);
    drive_ab(1, 0); tick(); chk("post_rst_st2", int'(st_a), 2);
    drive_ab(1, 1); tick(); chk("post_rst_st3", int'(st_a), 3);
    chk("post_rst_out", int'(out_a), 1);
    chk("post_rst_cnt", int'(cnt_a), 1);
    drive_ab(0, 0);

    // LEN=1 instance: saturating 2-bit counter and clear with a match.
    for (int k = 0; k < 5; k++) begin
      drive_c(1, 1, 0); tick();
      $display("c bit %0d: st=%0d out=%0b cnt=%0d", k, st_c, out_c, cnt_c);
      chk($sformatf("c_sat%0d_cnt", k), int'(cnt_c), (k < 3) ? k + 1 : 3);
      chk($sformatf("c_sat%0d_out", k), int'(out_c), 1);
    end
    drive_c(1, 0, 0); tick();
    chk("c_zero_st", int'(st_c), 0);
    chk("c_zero_cnt", int'(cnt_c), 3);
    drive_c(1, 1, 1); tick();
    chk("c_clr_cnt", int'(cnt_c), 0);
    chk("c_clr_out", int'(out_c), 1);
    drive_c(1, 1, 0); tick();
    chk("c_after_clr_cnt", int'(cnt_c), 1);
    drive_c(0, 0, 0); tick();
    chk("c_hold_out", int'(out_c), 1);

    // Random phase with the reference model, starting from a clean reset.
    pulse_reset();
    msa = 0; mca = 0; msb = 0; mcb = 0; mpat = 3'b101;
    for (int n = 0; n < 1500; n++) begin
      rv = ($urandom_range(0, 3) != 0);
      rb = 1'($urandom_range(0, 1));
      rl = ($urandom_range(0, 39) == 0);
      rc = ($urandom_range(0, 59) == 0);
      rp = 3'($urandom_range(0, 7));
      vld = rv; in_b = rb; load = rl; clr = rc; pat_in = rp;
      if (rl) begin
        mpat = rp;
        qa.delete(); qb.delete();
        msa = 0; msb = 0;
      end else if (rv) begin
        qa.push_back(rb);
        msa = longest(qa, mpat);
        if (msa == 3 && mca < 255) mca++;
        if (msb == 3) qb.delete();
        qb.push_back(rb);
        msb = longest(qb, mpat);
        if (msb == 3 && mcb < 255) mcb++;
      end
      if (rc) begin
        mca = 0; mcb = 0;
      end
      tick();
      chk("rnd_st_a", int'(st_a), msa);
      chk("rnd_out_a", int'(out_a), (msa == 3) ? 1 : 0);
      chk("rnd_cnt_a", int'(cnt_a), mca);
      chk("rnd_st_b", int'(st_b), msb);
      chk("rnd_cnt_b", int'(cnt_b), mcb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
